// File: rtl/instruction_memory_streamer_if.sv
// Load stream, status and fetch bus of the instruction memory streamer.
// The master side is the loader/PC; the slave side is the memory.
interface instruction_memory_streamer_if #(
    parameter int NB_DATA    = 32,
    parameter int NB_LOAD    = 8,
    parameter int NB_ADDRESS = 8
);
    logic                  i_clear;
    logic                  i_load_valid;
    logic [NB_LOAD-1:0]    i_load_data;
    logic                  o_load_ready;
    logic                  o_overflow;
    logic [NB_ADDRESS:0]   o_loaded_bytes;
    logic                  o_busy;
    logic [NB_ADDRESS-1:0] i_read_address;
    logic [NB_DATA-1:0]    o_read_instruction;
    logic                  o_misaligned;
    logic                  o_is_program_end;

    modport master (
        output i_clear, i_load_valid, i_load_data, i_read_address,
        input  o_load_ready, o_overflow, o_loaded_bytes, o_busy,
        input  o_read_instruction, o_misaligned, o_is_program_end
    );

    modport slave (
        input  i_clear, i_load_valid, i_load_data, i_read_address,
        output o_load_ready, o_overflow, o_loaded_bytes, o_busy,
        output o_read_instruction, o_misaligned, o_is_program_end
    );
endinterface

// File: rtl/instruction_memory_streamer.sv
// Instruction memory loaded big-endian from a beat stream, self-cleared by a
// one-word-per-cycle sweep, serving one registered fetch per cycle.
module instruction_memory_streamer #(
    parameter int NB_DATA        = 32,
    parameter int NB_LOAD        = 8,
    parameter int N_INSTRUCTIONS = 64,
    parameter int END_MARGIN     = 3,
    parameter int NB_ADDRESS     = $clog2(N_INSTRUCTIONS*NB_DATA/8)
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    instruction_memory_streamer_if.slave bus
);
    localparam int BPW            = NB_DATA / NB_LOAD;
    localparam int CAPACITY       = N_INSTRUCTIONS * BPW;
    localparam int NB_PTR         = $clog2(CAPACITY + 1);
    localparam int NB_WORD        = (N_INSTRUCTIONS > 1) ? $clog2(N_INSTRUCTIONS) : 1;
    localparam int NB_LANE        = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int NB_BYTE_OFF    = $clog2(NB_DATA / 8);
    localparam int BYTES_PER_BEAT = NB_LOAD / 8;
    localparam int END_BYTES      = END_MARGIN * NB_DATA / 8;

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t              r_state, w_state_next;
    logic [NB_WORD-1:0]  r_sweep, w_sweep_next;
    logic [NB_PTR-1:0]   r_beat_ptr, w_beat_ptr_next;
    logic [NB_ADDRESS:0] r_loaded_bytes, w_loaded_bytes_next;
    logic                r_overflow, w_overflow_next;
    logic                w_full, w_load_ready, w_accept;
    logic [NB_DATA-1:0]  r_mem [N_INSTRUCTIONS];
    logic [NB_WORD-1:0]  w_wr_word, w_rd_word;
    logic [NB_LANE-1:0]  w_wr_lane;
    logic [NB_ADDRESS+1:0] w_end_limit;
    logic                w_misaligned, w_program_end;
    logic [NB_DATA-1:0]  r_read_instruction;
    logic                r_misaligned, r_is_program_end;

    assign w_full       = (r_beat_ptr == NB_PTR'(CAPACITY));
    assign w_load_ready = (r_state == ST_IDLE) && !w_full && !bus.i_clear;
    assign w_accept     = w_load_ready && bus.i_load_valid;
    assign w_wr_word    = NB_WORD'(r_beat_ptr / NB_PTR'(BPW));
    assign w_wr_lane    = NB_LANE'(r_beat_ptr % NB_PTR'(BPW));

    // Fetch decode; the end limit is widened by one bit so it never wraps
    assign w_rd_word     = NB_WORD'(bus.i_read_address >> NB_BYTE_OFF);
    assign w_misaligned  = |(bus.i_read_address & NB_ADDRESS'(NB_DATA/8 - 1));
    assign w_end_limit   = {1'b0, r_loaded_bytes} + (NB_ADDRESS+2)'(END_BYTES);
    assign w_program_end = ({2'b00, bus.i_read_address} >= w_end_limit) ||
                           (w_rd_word == NB_WORD'(N_INSTRUCTIONS - 1));

    // Next-state logic: sweep sequencing, load pointer, overflow flag
    always_comb begin
        w_state_next        = r_state;
        w_sweep_next        = r_sweep;
        w_beat_ptr_next     = r_beat_ptr;
        w_loaded_bytes_next = r_loaded_bytes;
        w_overflow_next     = r_overflow;
        case (r_state)
            ST_CLEAR: begin
                if (r_sweep == NB_WORD'(N_INSTRUCTIONS - 1)) begin
                    w_state_next = ST_IDLE;
                    w_sweep_next = '0;
                end else begin
                    w_sweep_next = r_sweep + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.i_clear) begin
                    w_state_next        = ST_CLEAR;
                    w_sweep_next        = '0;
                    w_beat_ptr_next     = '0;
                    w_loaded_bytes_next = '0;
                    w_overflow_next     = 1'b0;
                end else if (w_accept) begin
                    w_beat_ptr_next     = r_beat_ptr + 1'b1;
                    w_loaded_bytes_next = r_loaded_bytes + (NB_ADDRESS+1)'(BYTES_PER_BEAT);
                end else if (bus.i_load_valid && w_full) begin
                    w_overflow_next = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_sweep_next = '0;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= ST_CLEAR;
            r_sweep        <= '0;
            r_beat_ptr     <= '0;
            r_loaded_bytes <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_sweep        <= w_sweep_next;
            r_beat_ptr     <= w_beat_ptr_next;
            r_loaded_bytes <= w_loaded_bytes_next;
            r_overflow     <= w_overflow_next;
        end
    end

    // Array write port: zero sweep, or one lane of the current word (lane 0 = MSBs)
    always_ff @(posedge i_clock) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_sweep] <= '0;
        end else if (w_accept) begin
            for (int l = 0; l < BPW; l++) begin
                if (w_wr_lane == NB_LANE'(l)) begin
                    r_mem[w_wr_word][NB_DATA-1-l*NB_LOAD -: NB_LOAD] <= bus.i_load_data;
                end
            end
        end
    end

    // Registered fetch port; returns pre-write contents on a same-edge write
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_read_instruction <= '0;
            r_misaligned       <= 1'b0;
            r_is_program_end   <= 1'b0;
        end else begin
            r_read_instruction <= r_mem[w_rd_word];
            r_misaligned       <= w_misaligned;
            r_is_program_end   <= w_program_end;
        end
    end

    assign bus.o_load_ready       = w_load_ready;
    assign bus.o_overflow         = r_overflow;
    assign bus.o_loaded_bytes     = r_loaded_bytes;
    assign bus.o_busy             = (r_state == ST_CLEAR);
    assign bus.o_read_instruction = r_read_instruction;
    assign bus.o_misaligned       = r_misaligned;
    assign bus.o_is_program_end   = r_is_program_end;
endmodule
